bcd_mod_counter: RTL and testbench

Parametrised BCD modulo counter, the general building block for all clock time fields (seconds, minutes, hours, day-of-month). It counts up or down on a single-cycle enable strobe in the system clock domain and holds its value directly as two BCD digits. It supports clear and validated parallel load, and emits one-cycle carry/borrow pulses so that stages cascade on one clock, with no derived clocks.

---
 rtl/bcd_mod_counter.sv | 178 +++++++++++++++++
 tb/tb_bcd_mod_counter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (MIN_VALUE..MIN_VALUE+MODULUS-1) with clear, validated load
// and single-cycle carry/borrow/load_err pulses for same-clock cascading of time fields.
module bcd_mod_counter #(
  parameter int MODULUS   = 60,
  parameter int MIN_VALUE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up_dn,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry,
  output logic       borrow,
  output logic       load_err
);

  localparam int MAX_VALUE = MIN_VALUE + MODULUS - 1;

  localparam logic [3:0] MIN_TENS = 4'(MIN_VALUE / 10);
  localparam logic [3:0] MIN_ONES = 4'(MIN_VALUE % 10);
  localparam logic [3:0] MAX_TENS = 4'(MAX_VALUE / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_VALUE % 10);

  typedef enum logic [2:0] {
    OP_HOLD    = 3'd0,
    OP_CLEAR   = 3'd1,
    OP_LOAD    = 3'd2,
    OP_REJECT  = 3'd3,
    OP_INC     = 3'd4,
    OP_DEC     = 3'd5,
    OP_RECOVER = 3'd6
  } op_e;

  function automatic logic is_digit(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  // Digit-wise comparisons avoid a binary conversion of the BCD value.
  function automatic logic bcd_ge(input logic [3:0] t, input logic [3:0] o,
                                  input logic [3:0] bt, input logic [3:0] bo);
    return (t > bt) || ((t == bt) && (o >= bo));
  endfunction

  function automatic logic bcd_le(input logic [3:0] t, input logic [3:0] o,
                                  input logic [3:0] bt, input logic [3:0] bo);
    return (t < bt) || ((t == bt) && (o <= bo));
  endfunction

  function automatic logic bcd_in_range(input logic [3:0] t, input logic [3:0] o);
    return is_digit(t) && is_digit(o) &&
           bcd_ge(t, o, MIN_TENS, MIN_ONES) &&
           bcd_le(t, o, MAX_TENS, MAX_ONES);
  endfunction

  logic [3:0] tens_r;
  logic [3:0] ones_r;
  logic       carry_r;
  logic       borrow_r;
  logic       load_err_r;

  logic [3:0] tens_nxt_s;
  logic [3:0] ones_nxt_s;
  logic       carry_nxt_s;
  logic       borrow_nxt_s;
  logic       load_err_nxt_s;

  logic       state_ok_s;
  logic       load_ok_s;
  logic       at_max_s;
  logic       at_min_s;
  op_e        op_s;

  assign state_ok_s = bcd_in_range(tens_r, ones_r);
  assign load_ok_s  = bcd_in_range(load_tens, load_ones);
  assign at_max_s   = (tens_r == MAX_TENS) && (ones_r == MAX_ONES);
  assign at_min_s   = (tens_r == MIN_TENS) && (ones_r == MIN_ONES);

  // Request decode: clear beats load beats en; a corrupted value recovers on en.
  always_comb begin
    op_s = OP_HOLD;
    if (clear) begin
      op_s = OP_CLEAR;
    end else if (load) begin
      op_s = load_ok_s ? OP_LOAD : OP_REJECT;
    end else if (en) begin
      if (!state_ok_s) begin
        op_s = OP_RECOVER;
      end else begin
        op_s = up_dn ? OP_INC : OP_DEC;
      end
    end else begin
      op_s = OP_HOLD;
    end
  end

  // Next value and pulse generation for the decoded operation.
  always_comb begin
    tens_nxt_s     = tens_r;
    ones_nxt_s     = ones_r;
    carry_nxt_s    = 1'b0;
    borrow_nxt_s   = 1'b0;
    load_err_nxt_s = 1'b0;
    case (op_s)
      OP_HOLD: begin
        tens_nxt_s = tens_r;
        ones_nxt_s = ones_r;
      end
      OP_CLEAR, OP_RECOVER: begin
        tens_nxt_s = MIN_TENS;
        ones_nxt_s = MIN_ONES;
      end
      OP_LOAD: begin
        tens_nxt_s = load_tens;
        ones_nxt_s = load_ones;
      end
      OP_REJECT: begin
        load_err_nxt_s = 1'b1;
      end
      OP_INC: begin
        if (at_max_s) begin
          tens_nxt_s  = MIN_TENS;
          ones_nxt_s  = MIN_ONES;
          carry_nxt_s = 1'b1;
        end else if (ones_r == 4'd9) begin
          tens_nxt_s = tens_r + 4'd1;
          ones_nxt_s = 4'd0;
        end else begin
          ones_nxt_s = ones_r + 4'd1;
        end
      end
      OP_DEC: begin
        if (at_min_s) begin
          tens_nxt_s   = MAX_TENS;
          ones_nxt_s   = MAX_ONES;
          borrow_nxt_s = 1'b1;
        end else if (ones_r == 4'd0) begin
          tens_nxt_s = tens_r - 4'd1;
          ones_nxt_s = 4'd9;
        end else begin
          ones_nxt_s = ones_r - 4'd1;
        end
      end
      default: begin
        tens_nxt_s = MIN_TENS;
        ones_nxt_s = MIN_ONES;
      end
    endcase
  end

  // Value and pulse registers; pulses share the edge with the value they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens_r     <= MIN_TENS;
      ones_r     <= MIN_ONES;
      carry_r    <= 1'b0;
      borrow_r   <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      tens_r     <= tens_nxt_s;
      ones_r     <= ones_nxt_s;
      carry_r    <= carry_nxt_s;
      borrow_r   <= borrow_nxt_s;
      load_err_r <= load_err_nxt_s;
    end
  end

  assign tens     = tens_r;
  assign ones     = ones_r;
  assign carry    = carry_r;
  assign borrow   = borrow_r;
  assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: table of single-cycle vectors on a 0..59 counter,
// plus hand sequences for 1..12 wrap, sec/min cascade and asynchronous reset mid-wrap.
module tb_bcd_mod_counter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // seconds-style instance 0..59
  logic s_en = 1'b0, s_up = 1'b0, s_clr = 1'b0, s_ld = 1'b0;
  logic [3:0] s_lt = 4'd0, s_lo = 4'd0, s_t, s_o;
  logic s_c, s_b, s_e;
  // 12-hour instance 1..12
  logic h_en = 1'b0, h_up = 1'b0, h_clr = 1'b0, h_ld = 1'b0;
  logic [3:0] h_lt = 4'd0, h_lo = 4'd0, h_t, h_o;
  logic h_c, h_b, h_e;
  // cascade: cs = seconds, cm = minutes
  logic cs_en = 1'b0, cs_up = 1'b1, cs_ld = 1'b0, cm_ld = 1'b0;
  logic [3:0] c_lt = 4'd0, c_lo = 4'd0, cs_t, cs_o, cm_t, cm_o;
  logic cs_c, cs_b, cs_e, cm_c, cm_b, cm_e;
  logic cup_d = 1'b0;

  always_ff @(posedge clk) cup_d <= cs_up;

  bcd_mod_counter #(.MODULUS(60), .MIN_VALUE(0)) u_sec (
    .clk(clk), .reset(reset), .en(s_en), .up_dn(s_up), .clear(s_clr), .load(s_ld),
    .load_tens(s_lt), .load_ones(s_lo), .tens(s_t), .ones(s_o),
    .carry(s_c), .borrow(s_b), .load_err(s_e));

  bcd_mod_counter #(.MODULUS(12), .MIN_VALUE(1)) u_hr (
    .clk(clk), .reset(reset), .en(h_en), .up_dn(h_up), .clear(h_clr), .load(h_ld),
    .load_tens(h_lt), .load_ones(h_lo), .tens(h_t), .ones(h_o),
    .carry(h_c), .borrow(h_b), .load_err(h_e));

  bcd_mod_counter #(.MODULUS(60), .MIN_VALUE(0)) u_csec (
    .clk(clk), .reset(reset), .en(cs_en), .up_dn(cs_up), .clear(1'b0), .load(cs_ld),
    .load_tens(c_lt), .load_ones(c_lo), .tens(cs_t), .ones(cs_o),
    .carry(cs_c), .borrow(cs_b), .load_err(cs_e));

  bcd_mod_counter #(.MODULUS(60), .MIN_VALUE(0)) u_cmin (
    .clk(clk), .reset(reset), .en(cs_c | cs_b), .up_dn(cup_d), .clear(1'b0), .load(cm_ld),
    .load_tens(c_lt), .load_ones(c_lo), .tens(cm_t), .ones(cm_o),
    .carry(cm_c), .borrow(cm_b), .load_err(cm_e));

  typedef struct {
    logic       clr;
    logic       ld;
    logic       en;
    logic       up;
    logic [3:0] lt;
    logic [3:0] lo;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [10:0] ex(input logic [3:0] t, input logic [3:0] o,
                                     input logic c, input logic b, input logic e);
    return {t, o, c, b, e};
  endfunction

  task automatic add(input logic clr, input logic ld, input logic en, input logic up,
                     input logic [3:0] lt, input logic [3:0] lo, input logic [10:0] exp);
    vec_t v;
    v.clr = clr; v.ld = ld; v.en = en; v.up = up; v.lt = lt; v.lo = lo; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got tens=%h ones=%h carry=%b borrow=%b load_err=%b, want tens=%h ones=%h carry=%b borrow=%b load_err=%b",
               name, act[10:7], act[6:3], act[2], act[1], act[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [10:0] e;
    // reset values
    reset = 1'b1;
    step();
    step();
    check("reset_sec", {s_t, s_o, s_c, s_b, s_e}, ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    check("reset_hr",  {h_t, h_o, h_c, h_b, h_e}, ex(4'd0, 4'd1, 1'b0, 1'b0, 1'b0));
    check("reset_cmin", {cm_t, cm_o, cm_c, cm_b, cm_e}, ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    reset = 1'b0;

    // up-count wrap over 60 cycles
    s_en = 1'b1; s_up = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      e = ex(4'((i % 60) / 10), 4'((i % 60) % 10), (i == 60), 1'b0, 1'b0);
      check($sformatf("wrap%0d", i), {s_t, s_o, s_c, s_b, s_e}, e);
    end
    s_en = 1'b0;

    // single-cycle vectors: clr ld en up lt lo -> tens ones carry borrow load_err
    add(1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd5,  4'd9,  ex(4'd5, 4'd9, 1'b0, 1'b0, 1'b0));
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd6,  4'd0,  ex(4'd5, 4'd9, 1'b0, 1'b0, 1'b1));
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd2,  4'd10, ex(4'd5, 4'd9, 1'b0, 1'b0, 1'b1));
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  ex(4'd5, 4'd9, 1'b0, 1'b0, 1'b0));
    add(1'b1, 1'b1, 1'b1, 1'b1, 4'd3,  4'd4,  ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd5,  4'd9,  ex(4'd5, 4'd9, 1'b0, 1'b0, 1'b0));
    add(1'b0, 1'b1, 1'b1, 1'b1, 4'd3,  4'd4,  ex(4'd3, 4'd4, 1'b0, 1'b0, 1'b0));
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  ex(4'd3, 4'd3, 1'b0, 1'b0, 1'b0));
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd4,  4'd0,  ex(4'd4, 4'd0, 1'b0, 1'b0, 1'b0));
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  ex(4'd3, 4'd9, 1'b0, 1'b0, 1'b0));
    add(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  ex(4'd4, 4'd0, 1'b0, 1'b0, 1'b0));
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  ex(4'd4, 4'd0, 1'b0, 1'b0, 1'b0));
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  ex(4'd5, 4'd9, 1'b0, 1'b1, 1'b0));
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  ex(4'd5, 4'd9, 1'b0, 1'b0, 1'b0));
    add(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  ex(4'd0, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd9,  4'd9,  ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b1));
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 4'd0,  ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b1));
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'd4,  4'd2,  ex(4'd4, 4'd2, 1'b0, 1'b0, 1'b0));
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  ex(4'd4, 4'd2, 1'b0, 1'b0, 1'b0));

    foreach (vecs[i]) begin
      s_clr = vecs[i].clr; s_ld = vecs[i].ld; s_en = vecs[i].en; s_up = vecs[i].up;
      s_lt = vecs[i].lt; s_lo = vecs[i].lo;
      step();
      check($sformatf("vec%0d", i), {s_t, s_o, s_c, s_b, s_e}, vecs[i].exp);
    end
    s_clr = 1'b0; s_ld = 1'b0; s_en = 1'b0;

    // 1..12 counter: down-wrap, up-wrap, load bounds
    h_ld = 1'b1; h_lt = 4'd0; h_lo = 4'd1;
    step(); check("hr_load01", {h_t, h_o, h_c, h_b, h_e}, ex(4'd0, 4'd1, 1'b0, 1'b0, 1'b0));
    h_ld = 1'b0; h_en = 1'b1; h_up = 1'b0;
    step(); check("hr_down_wrap", {h_t, h_o, h_c, h_b, h_e}, ex(4'd1, 4'd2, 1'b0, 1'b1, 1'b0));
    h_up = 1'b1;
    step(); check("hr_up_wrap", {h_t, h_o, h_c, h_b, h_e}, ex(4'd0, 4'd1, 1'b1, 1'b0, 1'b0));
    h_en = 1'b0;
    step(); check("hr_idle", {h_t, h_o, h_c, h_b, h_e}, ex(4'd0, 4'd1, 1'b0, 1'b0, 1'b0));
    h_ld = 1'b1; h_lt = 4'd0; h_lo = 4'd0;
    step(); check("hr_load00", {h_t, h_o, h_c, h_b, h_e}, ex(4'd0, 4'd1, 1'b0, 1'b0, 1'b1));
    h_lt = 4'd1; h_lo = 4'd3;
    step(); check("hr_load13", {h_t, h_o, h_c, h_b, h_e}, ex(4'd0, 4'd1, 1'b0, 1'b0, 1'b1));
    h_lt = 4'd1; h_lo = 4'd0;
    step(); check("hr_load10", {h_t, h_o, h_c, h_b, h_e}, ex(4'd1, 4'd0, 1'b0, 1'b0, 1'b0));
    h_ld = 1'b0; h_en = 1'b1; h_up = 1'b0;
    step(); check("hr_dec10", {h_t, h_o, h_c, h_b, h_e}, ex(4'd0, 4'd9, 1'b0, 1'b0, 1'b0));
    h_up = 1'b1;
    step(); check("hr_inc09", {h_t, h_o, h_c, h_b, h_e}, ex(4'd1, 4'd0, 1'b0, 1'b0, 1'b0));
    h_en = 1'b0;

    // sec/min cascade, up then down
    cs_ld = 1'b1; cm_ld = 1'b1; c_lt = 4'd5; c_lo = 4'd9;
    step();
    check("cas_pre_sec", {cs_t, cs_o, cs_c, cs_b, cs_e}, ex(4'd5, 4'd9, 1'b0, 1'b0, 1'b0));
    check("cas_pre_min", {cm_t, cm_o, cm_c, cm_b, cm_e}, ex(4'd5, 4'd9, 1'b0, 1'b0, 1'b0));
    cs_ld = 1'b0; cm_ld = 1'b0; cs_en = 1'b1; cs_up = 1'b1;
    step();
    check("cas_n_sec", {cs_t, cs_o, cs_c, cs_b, cs_e}, ex(4'd0, 4'd0, 1'b1, 1'b0, 1'b0));
    check("cas_n_min", {cm_t, cm_o, cm_c, cm_b, cm_e}, ex(4'd5, 4'd9, 1'b0, 1'b0, 1'b0));
    cs_en = 1'b0;
    step();
    check("cas_n1_sec", {cs_t, cs_o, cs_c, cs_b, cs_e}, ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    check("cas_n1_min", {cm_t, cm_o, cm_c, cm_b, cm_e}, ex(4'd0, 4'd0, 1'b1, 1'b0, 1'b0));
    step();
    check("cas_n2_min", {cm_t, cm_o, cm_c, cm_b, cm_e}, ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    cs_en = 1'b1; cs_up = 1'b0;
    step();
    check("cas_dn_sec", {cs_t, cs_o, cs_c, cs_b, cs_e}, ex(4'd5, 4'd9, 1'b0, 1'b1, 1'b0));
    cs_en = 1'b0;
    step();
    check("cas_dn_min", {cm_t, cm_o, cm_c, cm_b, cm_e}, ex(4'd5, 4'd9, 1'b0, 1'b1, 1'b0));
    cs_up = 1'b1;

    // async reset in the cycle carry is high
    cs_ld = 1'b1; cm_ld = 1'b1; c_lt = 4'd5; c_lo = 4'd9;
    step();
    cs_ld = 1'b0; cm_ld = 1'b0; cs_en = 1'b1;
    step();
    check("ar_carry", {cs_t, cs_o, cs_c, cs_b, cs_e}, ex(4'd0, 4'd0, 1'b1, 1'b0, 1'b0));
    cs_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("ar_sec", {cs_t, cs_o, cs_c, cs_b, cs_e}, ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    check("ar_min", {cm_t, cm_o, cm_c, cm_b, cm_e}, ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    check("ar_u_sec", {s_t, s_o, s_c, s_b, s_e}, ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    step();
    reset = 1'b0;
    step();
    check("ar_after_min", {cm_t, cm_o, cm_c, cm_b, cm_e}, ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    check("ar_after_sec", {s_t, s_o, s_c, s_b, s_e}, ex(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    s_en = 1'b1; s_up = 1'b1;
    step();
    check("ar_first_count", {s_t, s_o, s_c, s_b, s_e}, ex(4'd0, 4'd1, 1'b0, 1'b0, 1'b0));
    s_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
